// File: rtl/minimax_rf_pkg.sv
// Shared types and defaults for the minimax register file controller.
// Parity protection is compiled in with the RF_PARITY_EN macro.
package minimax_rf_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_XLEN_DEF   = 32;
  localparam int RF_NREGS_DEF  = 32;
  localparam int RF_ADDR_W_DEF = 5;
  localparam int RF_ZERO_IDX   = 0;

endpackage

// File: rtl/minimax_rf_ctl_if.sv
// Bus between decode/writeback logic (master) and the register file (slave).
// RF_PARITY_EN adds the par_inject / parity_err pair.
interface minimax_rf_ctl_if
  import minimax_rf_pkg::*;
#(
  parameter int XLEN   = RF_XLEN_DEF,
  parameter int ADDR_W = RF_ADDR_W_DEF
);
  logic [ADDR_W-1:0] addrS;
  logic [ADDR_W-1:0] addrD;
  logic [XLEN-1:0]   new_value;
  logic              we;
  logic              clear_req;
  logic              ready;
  logic              busy;
  logic [XLEN-1:0]   rS;
  logic [XLEN-1:0]   rD;
`ifdef RF_PARITY_EN
  logic              par_inject;
  logic              parity_err;

  modport master (
    output addrS, addrD, new_value, we, clear_req, par_inject,
    input  ready, busy, rS, rD, parity_err
  );
  modport slave (
    input  addrS, addrD, new_value, we, clear_req, par_inject,
    output ready, busy, rS, rD, parity_err
  );
`else
  modport master (
    output addrS, addrD, new_value, we, clear_req,
    input  ready, busy, rS, rD
  );
  modport slave (
    input  addrS, addrD, new_value, we, clear_req,
    output ready, busy, rS, rD
  );
`endif
endinterface

// File: rtl/minimax_rf_clr_seq.sv
// Clear sequencer: walks entries 1..NREGS-1 writing zero after reset or a
// clear request, then parks in RF_READY.
module minimax_rf_clr_seq
  import minimax_rf_pkg::*;
#(
  parameter int NREGS  = RF_NREGS_DEF,
  parameter int ADDR_W = RF_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(32'd1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(NREGS - 1);

  rf_state_e         state_r;
  rf_state_e         state_s;
  logic [ADDR_W-1:0] clr_ptr_r;
  logic [ADDR_W-1:0] clr_ptr_s;

  // State and pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= RF_CLEAR;
      clr_ptr_r <= PTR_FIRST;
    end else begin
      state_r   <= state_s;
      clr_ptr_r <= clr_ptr_s;
    end
  end

  // Next-state logic; clear requests are ignored while already clearing.
  always_comb begin
    state_s   = state_r;
    clr_ptr_s = clr_ptr_r;
    case (state_r)
      RF_CLEAR: begin
        if (clr_ptr_r == PTR_LAST) begin
          state_s   = RF_READY;
          clr_ptr_s = PTR_FIRST;
        end else begin
          state_s   = RF_CLEAR;
          clr_ptr_s = clr_ptr_r + ADDR_W'(32'd1);
        end
      end
      RF_READY: begin
        if (clear_req) begin
          state_s   = RF_CLEAR;
          clr_ptr_s = PTR_FIRST;
        end else begin
          state_s   = RF_READY;
          clr_ptr_s = clr_ptr_r;
        end
      end
      default: begin
        state_s   = RF_CLEAR;
        clr_ptr_s = PTR_FIRST;
      end
    endcase
  end

  // Outputs decoded from the state register only.
  always_comb begin
    busy     = 1'b1;
    clr_we   = 1'b1;
    clr_addr = clr_ptr_r;
    case (state_r)
      RF_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
      end
      RF_READY: begin
        busy   = 1'b0;
        clr_we = 1'b0;
      end
      default: begin
        busy   = 1'b1;
        clr_we = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/minimax_rf_ctl.sv
// minimax register file: two combinational read ports, registered write stage
// with bypass, hardware clear. RF_PARITY_EN adds per-entry even parity.
module minimax_rf_ctl
  import minimax_rf_pkg::*;
#(
  parameter int XLEN   = RF_XLEN_DEF,
  parameter int NREGS  = RF_NREGS_DEF,
  parameter int ADDR_W = RF_ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  minimax_rf_ctl_if.slave  bus
);

  localparam int                IDX_W   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [ADDR_W:0]   NREGS_X = (ADDR_W + 1)'(NREGS);
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(RF_ZERO_IDX);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != ZERO_A) && ({1'b0, a} < NREGS_X);
  endfunction

  function automatic logic even_par(input logic [XLEN-1:0] d);
    return ^d;
  endfunction

  logic              busy_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              ready_s;
  logic              wr_accept_s;
  logic              commit_s;

  logic              wb_valid_r;
  logic [ADDR_W-1:0] wb_addr_r;
  logic [XLEN-1:0]   wb_data_r;

  logic [XLEN-1:0]   mem_r [NREGS];
`ifdef RF_PARITY_EN
  logic              mem_par_r [NREGS];
  logic [1:0]        rd_perr_s;
`endif

  logic [ADDR_W-1:0] rd_addr_s [2];
  logic [XLEN-1:0]   rd_data_s [2];

  minimax_rf_clr_seq #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_req (bus.clear_req),
    .busy      (busy_s),
    .clr_we    (clr_we_s),
    .clr_addr  (clr_addr_s)
  );

  // A clear request in READY both refuses the new write and kills the pending one.
  assign ready_s     = ~busy_s & ~bus.clear_req;
  assign wr_accept_s = bus.we & ready_s & addr_ok(bus.addrD);
  assign commit_s    = wb_valid_r & ready_s;

  // Write stage register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_r <= 1'b0;
      wb_addr_r  <= '0;
      wb_data_r  <= '0;
    end else begin
      wb_valid_r <= wr_accept_s;
      if (wr_accept_s) begin
        wb_addr_r <= bus.addrD;
        wb_data_r <= bus.new_value;
      end
    end
  end

  // Storage array: cleared by the sequencer, otherwise loaded from the write stage.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[clr_addr_s[IDX_W-1:0]] <= '0;
`ifdef RF_PARITY_EN
      mem_par_r[clr_addr_s[IDX_W-1:0]] <= 1'b0;
`endif
    end else if (commit_s) begin
      mem_r[wb_addr_r[IDX_W-1:0]] <= wb_data_r;
`ifdef RF_PARITY_EN
      mem_par_r[wb_addr_r[IDX_W-1:0]] <= even_par(wb_data_r) ^ bus.par_inject;
`endif
    end
  end

  assign rd_addr_s[0] = bus.addrS;
  assign rd_addr_s[1] = bus.addrD;

  // Read muxes: zero for x0/out-of-range/clearing, bypass, then array.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_s[p] = '0;
`ifdef RF_PARITY_EN
      rd_perr_s[p] = 1'b0;
`endif
      if (busy_s || !addr_ok(rd_addr_s[p])) begin
        rd_data_s[p] = '0;
      end else if (wb_valid_r && (wb_addr_r == rd_addr_s[p])) begin
        rd_data_s[p] = wb_data_r;
      end else begin
        rd_data_s[p] = mem_r[rd_addr_s[p][IDX_W-1:0]];
`ifdef RF_PARITY_EN
        rd_perr_s[p] = even_par(mem_r[rd_addr_s[p][IDX_W-1:0]]) !=
                       mem_par_r[rd_addr_s[p][IDX_W-1:0]];
`endif
      end
    end
  end

  assign bus.rS    = rd_data_s[0];
  assign bus.rD    = rd_data_s[1];
  assign bus.ready = ready_s;
  assign bus.busy  = busy_s;
`ifdef RF_PARITY_EN
  assign bus.parity_err = |rd_perr_s;
`endif

endmodule

// File: tb/tb_minimax_rf_ctl.sv
// Randomised bench for minimax_rf_ctl: a 32-entry and a 16-entry instance share
// stimulus and are checked against an abstract register-file model.
module tb_minimax_rf_ctl;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   addr_s, addr_d;
  logic [XLEN-1:0] new_value;
  logic            we, clear_req;
`ifdef RF_PARITY_EN
  logic            par_inject;
  logic [1:0]      perr_o;
`endif

  minimax_rf_ctl_if #(.XLEN(XLEN), .ADDR_W(AW)) bus0 ();
  minimax_rf_ctl_if #(.XLEN(XLEN), .ADDR_W(AW)) bus1 ();

  minimax_rf_ctl #(.XLEN(XLEN), .NREGS(32), .ADDR_W(AW)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  minimax_rf_ctl #(.XLEN(XLEN), .NREGS(16), .ADDR_W(AW)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  assign bus0.addrS = addr_s;  assign bus1.addrS = addr_s;
  assign bus0.addrD = addr_d;  assign bus1.addrD = addr_d;
  assign bus0.new_value = new_value;  assign bus1.new_value = new_value;
  assign bus0.we = we;  assign bus1.we = we;
  assign bus0.clear_req = clear_req;  assign bus1.clear_req = clear_req;
`ifdef RF_PARITY_EN
  assign bus0.par_inject = par_inject;  assign bus1.par_inject = par_inject;
  assign perr_o[0] = bus0.parity_err;   assign perr_o[1] = bus1.parity_err;
`endif

  logic [XLEN-1:0] rs_o [2];
  logic [XLEN-1:0] rd_o [2];
  logic            busy_o [2];
  logic            ready_o [2];
  assign rs_o[0] = bus0.rS;  assign rs_o[1] = bus1.rS;
  assign rd_o[0] = bus0.rD;  assign rd_o[1] = bus1.rD;
  assign busy_o[0] = bus0.busy;  assign busy_o[1] = bus1.busy;
  assign ready_o[0] = bus0.ready;  assign ready_o[1] = bus1.ready;

  // Reference model: architectural contents, one pending write, clear countdown.
  int              nr [2] = '{32, 16};
  logic [XLEN-1:0] regs [2][32];
  bit              bad [2][32];
  int              clr_left [2];
  bit              pend_v [2];
  int              pend_a [2];
  logic [XLEN-1:0] pend_d [2];
  bit              in_rst;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [XLEN-1:0] got,
                           input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_busy(int i);
    return in_rst || (clr_left[i] > 0);
  endfunction

  function automatic bit arr_src(int i, int a);
    return !m_busy(i) && a != 0 && a < nr[i] && !(pend_v[i] && pend_a[i] == a);
  endfunction

  function automatic logic [XLEN-1:0] m_read(int i, int a);
    if (m_busy(i) || a == 0 || a >= nr[i]) return '0;
    if (pend_v[i] && pend_a[i] == a) return pend_d[i];
    return regs[i][a];
  endfunction

  function automatic bit m_perr(int i);
    return (arr_src(i, int'(addr_s)) && bad[i][addr_s]) ||
           (arr_src(i, int'(addr_d)) && bad[i][addr_d]);
  endfunction

  task automatic m_start_clear(int i);
    clr_left[i] = nr[i] - 1;
    pend_v[i] = 1'b0;
    for (int a = 0; a < 32; a++) begin
      regs[i][a] = '0;
      bad[i][a] = 1'b0;
    end
  endtask

  task automatic m_edge();
    for (int i = 0; i < 2; i++) begin
      if (in_rst) begin
        m_start_clear(i);
      end else if (clr_left[i] > 0) begin
        clr_left[i]--;
      end else if (clear_req) begin
        m_start_clear(i);
      end else begin
        if (pend_v[i]) begin
          regs[i][pend_a[i]] = pend_d[i];
`ifdef RF_PARITY_EN
          bad[i][pend_a[i]] = par_inject;
`endif
        end
        pend_v[i] = we && addr_d != 0 && int'(addr_d) < nr[i];
        pend_a[i] = int'(addr_d);
        pend_d[i] = new_value;
      end
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("i%0d_busy", i), busy_o[i], m_busy(i));
      check_val($sformatf("i%0d_ready", i), ready_o[i], !m_busy(i) && !clear_req);
      check_val($sformatf("i%0d_rS_a%0d", i, addr_s), rs_o[i], m_read(i, int'(addr_s)));
      check_val($sformatf("i%0d_rD_a%0d", i, addr_d), rd_o[i], m_read(i, int'(addr_d)));
`ifdef RF_PARITY_EN
      check_val($sformatf("i%0d_perr", i), perr_o[i], m_perr(i));
`endif
    end
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic do_reset(int cyc);
    reset_n = 1'b0;
    in_rst = 1'b1;
    for (int i = 0; i < 2; i++) m_start_clear(i);
    repeat (cyc) step();
    reset_n = 1'b1;
    in_rst = 1'b0;
  endtask

  task automatic wait_clear_len();
    int cnt = 0;
    while (bus0.busy && cnt < 100) begin
      step();
      cnt++;
    end
    check_val("busy_len", cnt, 31);
  endtask

  task automatic wr(input int a, input logic [XLEN-1:0] v);
    we = 1'b1; addr_d = AW'(a); new_value = v;
    step();
  endtask

  initial begin
    we = 1'b0; clear_req = 1'b0; addr_s = '0; addr_d = '0; new_value = '0;
`ifdef RF_PARITY_EN
    par_inject = 1'b0;
`endif
    #1;
    do_reset(3);
    addr_s = AW'(5);
    wait_clear_len();
    check_val("x5_after_clear", bus0.rS, 32'h0);

    // Write x3, observe bypass then array; x0 write must stay invisible.
    addr_s = AW'(3);
    wr(3, 32'hDEADBEEF);
    check_val("x3_bypass", bus0.rS, 32'hDEADBEEF);
    we = 1'b0; step();
    check_val("x3_array", bus0.rS, 32'hDEADBEEF);
    addr_s = AW'(0);
    wr(0, 32'h1234);
    we = 1'b0; step();
    check_val("x0_zero", bus0.rS, 32'h0);

    // Out-of-range write for the 16-entry instance.
    wr(4, 32'h44);
    wr(20, 32'hA5A5A5A5);
    we = 1'b0; addr_s = AW'(20); addr_d = AW'(4); step();
    check_val("x20_small", bus1.rS, 32'h0);
    check_val("x20_big", bus0.rS, 32'hA5A5A5A5);
    check_val("x4_small", bus1.rD, 32'h44);

    // Back-to-back writes.
    addr_s = AW'(7);
    wr(7, 32'd1);
    check_val("x7_1", bus0.rS, 32'd1);
    wr(7, 32'd2);
    check_val("x7_2", bus0.rS, 32'd2);
    wr(8, 32'd3);
    we = 1'b0; addr_d = AW'(8);
    check_val("x8_3", bus0.rD, 32'd3);
    step();

    // Clear coincident with a write, then sweep all addresses.
    wr(9, 32'h11);
    clear_req = 1'b1; wr(9, 32'h55);
    clear_req = 1'b0; we = 1'b0;
    wait_clear_len();
    for (int a = 0; a < 32; a++) begin
      addr_s = AW'(a); addr_d = AW'(31 - a);
      step();
    end

    // Reset in the middle of a clear restarts the full sequence.
    clear_req = 1'b1; step();
    clear_req = 1'b0;
    repeat (10) step();
    do_reset(2);
    wait_clear_len();

`ifdef RF_PARITY_EN
    // Corrupted parity visible only once the value is array-sourced.
    addr_s = AW'(2); addr_d = AW'(0);
    par_inject = 1'b1;
    wr(2, 32'h1);
    we = 1'b0; addr_d = AW'(0);
    check_val("par_bypass", bus0.parity_err, 1'b0);
    step();
    check_val("par_arr", bus0.parity_err, 1'b1);
    par_inject = 1'b0;
    wr(2, 32'h3);
    we = 1'b0; step();
`endif

    // Random traffic with rare clears and resets.
    for (int n = 0; n < 2500; n++) begin
      we        = ($urandom_range(0, 3) != 0);
      addr_d    = AW'($urandom_range(0, 31));
      addr_s    = AW'($urandom_range(0, 31));
      new_value = $urandom;
      clear_req = ($urandom_range(0, 149) == 0);
`ifdef RF_PARITY_EN
      par_inject = ($urandom_range(0, 15) == 0);
`endif
      if ($urandom_range(0, 599) == 0) do_reset(2);
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
